// File: rtl/fb_scanout.sv
// VGA raster scan-out for a 1-bit framebuffer: counters, sequential read addresses,
// and a fixed-latency realignment pipeline that pairs returned pixels with sync/enable.
module fb_scanout #(
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter int          SYNC_ACTIVE_LOW = 1,
    parameter int          ADDR_WIDTH      = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int          MEM_LATENCY     = 2,
    parameter logic [23:0] FG_COLOR        = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR        = 24'h000000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic                  rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [23:0]           rgb,
    output logic                  vblank,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } ctrl_t;

    function automatic logic sync_level(input logic on);
        return (SYNC_ACTIVE_LOW != 0) ? ~on : on;
    endfunction

    function automatic logic [23:0] pixel_color(input logic en, input logic bit_i);
        if (!en)
            return 24'h000000;
        return bit_i ? FG_COLOR : BG_COLOR;
    endfunction

    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  active;
    logic                  hs_on;
    logic                  vs_on;

    ctrl_t                 ctrl_p_q [MEM_LATENCY];
    logic                  hsync_q;
    logic                  vsync_q;
    logic                  de_q;
    logic [23:0]           rgb_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_on  = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
    assign vs_on  = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);

    // Address tracks the raster with a plain counter; it holds through blanking so
    // each new line resumes exactly where the previous one ended.
    always_comb begin
        addr_d = addr_q;
        if (active)
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Stage 0: registered sync/active decode, then delay to match memory latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MEM_LATENCY; k++)
                ctrl_p_q[k] <= '0;
        end else begin
            ctrl_p_q[0] <= '{hs: hs_on, vs: vs_on, act: active};
            for (int k = 1; k < MEM_LATENCY; k++)
                ctrl_p_q[k] <= ctrl_p_q[k-1];
        end
    end

    // Output stage: rd_data is valid now, paired with the last delayed controls
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= sync_level(1'b0);
            vsync_q <= sync_level(1'b0);
            de_q    <= 1'b0;
            rgb_q   <= 24'h000000;
        end else begin
            hsync_q <= sync_level(ctrl_p_q[MEM_LATENCY-1].hs);
            vsync_q <= sync_level(ctrl_p_q[MEM_LATENCY-1].vs);
            de_q    <= ctrl_p_q[MEM_LATENCY-1].act;
            rgb_q   <= pixel_color(ctrl_p_q[MEM_LATENCY-1].act, rd_data);
        end
    end

    // Counter-domain strobes are masked while reset is held so they read as idle.
    assign rd_addr     = addr_q;
    assign rd_en       = active && !reset;
    assign vblank      = (v_cnt_q >= V_ACT) && !reset;
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0) && !reset;

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced raster, with latency-2 and latency-1 instances
// fed by a one-lit-pixel memory model.
module tb_fb_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int AW = $clog2(HA * VA);
    localparam int LIT_ADDR = 3 * HA + 5;
    localparam logic [23:0] FG_B = 24'hABCDEF;
    localparam logic [23:0] BG_B = 24'h123456;

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    logic [AW-1:0] addr_a, addr_b;
    logic          en_a, en_b, dat_a, dat_b;
    logic          hs_a, hs_b, vs_a, vs_b, de_a, de_b, vb_a, vb_b, fs_a, fs_b;
    logic [23:0]   rgb_a, rgb_b;
    logic [1:0]    mem_a = 2'b11;
    logic          mem_b = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_LOW(1), .ADDR_WIDTH(AW), .MEM_LATENCY(2),
        .FG_COLOR(24'hFFFFFF), .BG_COLOR(24'h000000)
    ) dut_a (
        .clk(clk), .reset(reset), .rd_addr(addr_a), .rd_en(en_a), .rd_data(dat_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a), .vblank(vb_a),
        .frame_start(fs_a)
    );

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_LOW(1), .ADDR_WIDTH(AW), .MEM_LATENCY(1),
        .FG_COLOR(FG_B), .BG_COLOR(BG_B)
    ) dut_b (
        .clk(clk), .reset(reset), .rd_addr(addr_b), .rd_en(en_b), .rd_data(dat_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b), .vblank(vb_b),
        .frame_start(fs_b)
    );

    // Idle reads return 1 so a missing blanking mask shows up as colour.
    function automatic logic pix(input logic [AW-1:0] a);
        return (int'(a) == LIT_ADDR);
    endfunction

    always @(posedge clk) begin
        mem_a <= {mem_a[0], en_a ? pix(addr_a) : 1'b1};
        mem_b <= en_b ? pix(addr_b) : 1'b1;
    end
    assign dat_a = mem_a[1];
    assign dat_b = mem_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cycle(input int n, input string id, input int lat,
                             input logic [23:0] fg, input logic [23:0] bg,
                             input logic [AW-1:0] addr, input logic en, input logic fs,
                             input logic vb, input logic hs, input logic vs,
                             input logic de_o, input logic [23:0] rgb_o);
        int h, v, m, hm, vm;
        logic act, ehs, evs, ede;
        logic [23:0] ergb;
        h   = n % HT;
        v   = (n / HT) % VT;
        act = (h < HA) && (v < VA);
        chk($sformatf("%s_rd_en@%0d", id, n), en, act);
        if (act)
            chk($sformatf("%s_rd_addr@%0d", id, n), addr, v * HA + h);
        chk($sformatf("%s_frame_start@%0d", id, n), fs, (h == 0) && (v == 0));
        chk($sformatf("%s_vblank@%0d", id, n), vb, v >= VA);
        m = n - lat - 1;
        if (m < 0) begin
            ehs = 1'b1; evs = 1'b1; ede = 1'b0; ergb = 24'h0;
        end else begin
            hm   = m % HT;
            vm   = (m / HT) % VT;
            ehs  = !((hm >= HA + HF) && (hm < HA + HF + HS));
            evs  = !((vm >= VA + VF) && (vm < VA + VF + VS));
            ede  = (hm < HA) && (vm < VA);
            ergb = ede ? (((hm == 5) && (vm == 3)) ? fg : bg) : 24'h0;
        end
        chk($sformatf("%s_hsync@%0d", id, n), hs, ehs);
        chk($sformatf("%s_vsync@%0d", id, n), vs, evs);
        chk($sformatf("%s_de@%0d", id, n), de_o, ede);
        chk($sformatf("%s_rgb@%0d", id, n), rgb_o, ergb);
    endtask

    task automatic chk_both(input int n);
        chk_cycle(n, "a", 2, 24'hFFFFFF, 24'h000000, addr_a, en_a, fs_a, vb_a,
                  hs_a, vs_a, de_a, rgb_a);
        chk_cycle(n, "b", 1, FG_B, BG_B, addr_b, en_b, fs_b, vb_b,
                  hs_b, vs_b, de_b, rgb_b);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en_a", en_a, 0);
        chk("rst_rd_addr_a", addr_a, 0);
        chk("rst_frame_start_a", fs_a, 0);
        chk("rst_vblank_a", vb_a, 0);
        chk("rst_hsync_a", hs_a, 1);
        chk("rst_vsync_a", vs_a, 1);
        chk("rst_de_a", de_a, 0);
        chk("rst_rgb_a", rgb_a, 0);
        chk("rst_rd_en_b", en_b, 0);
        chk("rst_hsync_b", hs_b, 1);
        chk("rst_de_b", de_b, 0);
        chk("rst_rgb_b", rgb_b, 0);

        @(posedge clk);
        #1 reset = 1'b0;
        // Two full frames plus the start of a third, stopping at (h=4, v=2)
        for (int n = 0; n <= 2 * HT * VT + 2 * HT + 4; n++) begin
            @(negedge clk);
            chk_both(n);
            if (n == HT * VT - (VT - VA) * HT - (HT - HA) - 1)
                chk("last_pixel_addr_a", addr_a, HA * VA - 1);
            if (n == HT * VT)
                chk("wrap_addr_a", addr_a, 0);
            if (n == 3 * HT + 5 + 3)
                chk("lit_pixel_a", rgb_a, 24'hFFFFFF);
            if (n == 3 * HT + 5 + 2)
                chk("lit_pixel_b", rgb_b, FG_B);
        end

        // One-cycle reset mid-frame
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_frame_start_a", fs_a, 1);
        chk("mid_rst_rd_addr_a", addr_a, 0);
        chk("mid_rst_rd_en_a", en_a, 1);
        chk("mid_rst_de_a", de_a, 0);
        chk("mid_rst_rgb_a", rgb_a, 0);
        chk("mid_rst_hsync_a", hs_a, 1);
        chk("mid_rst_vsync_a", vs_a, 1);
        chk("mid_rst_de_b", de_b, 0);
        chk_both(0);
        for (int n = 1; n < 4 * HT; n++) begin
            @(negedge clk);
            chk_both(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
